// File: rtl/ib_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ib_chk_pkg
//  Description : Shared opcode constants, ITSTATE reset value and the ITSTATE
//                advance helper for the Thumb-16 branch/IT checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package ib_chk_pkg;

  // Opcode / field match constants
  localparam logic [7:0] c_it_op       = 8'hBF;        // inst[15:8]
  localparam logic [3:0] c_cond_b_op   = 4'hD;         // inst[15:12]
  localparam logic [2:0] c_cond_excl   = 3'b111;       // inst[11:9]: UDF / SVC
  localparam logic [4:0] c_uncond_b_op = 5'b11100;     // inst[15:11]
  localparam logic [8:0] c_bx_op       = 9'b010001110; // inst[15:7]
  localparam logic [8:0] c_blx_op      = 9'b010001111; // inst[15:7]
  localparam logic [3:0] c_cb_op       = 4'hB;         // inst[15:12]

  // ITSTATE value outside any IT block
  localparam logic [7:0] c_itstate_rst = 8'h00;

  // Step ITSTATE past one instruction of an active IT block. When only the
  // terminating one remains in the mask the block is finished; otherwise the
  // mask (with the condition LSB) shifts left and the base condition holds.
  function automatic logic [7:0] itstate_advance(input logic [7:0] state);
    logic [7:0] next_state;
    if (state[2:0] == 3'b000) begin
      next_state = c_itstate_rst;
    end else begin
      next_state = {state[7:5], state[3:0], 1'b0};
    end
    return next_state;
  endfunction

endpackage : ib_chk_pkg
`default_nettype wire

// File: rtl/ib_chk_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ib_chk_decode
//  Description : Combinational classifier of one Thumb-16 halfword into
//                16-bit branch and IT instruction flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ib_chk_decode
  import ib_chk_pkg::*;
(
  input  logic [15:0] inst,
  output logic        b_d,
  output logic        it_d
);

  logic w_cond_b;
  logic w_uncond_b;
  logic w_bx_blx;
  logic w_cbz;

  // Decode each branch class and the IT instruction from the raw halfword
  always_comb begin
    // Conditional B excluding cond E (UDF) and F (SVC)
    w_cond_b   = (inst[15:12] == c_cond_b_op) && (inst[11:9] != c_cond_excl);
    w_uncond_b = (inst[15:11] == c_uncond_b_op);
    // BX / BLX register form; Rm and the SBZ bits are don't-care
    w_bx_blx   = (inst[15:7] == c_bx_op) || (inst[15:7] == c_blx_op);
    // CBZ / CBNZ: op bit 11 is the Z/NZ select, bits 10 and 8 fix the class
    w_cbz      = (inst[15:12] == c_cb_op) && !inst[10] && inst[8];
    b_d        = w_cond_b || w_uncond_b || w_bx_blx || w_cbz;
    // A zero mask is a hint (NOP/YIELD/...), not an IT
    it_d       = (inst[15:8] == c_it_op) && (inst[3:0] != 4'h0);
  end

endmodule : ib_chk_decode
`default_nettype wire

// File: rtl/ib_chk.sv
`default_nettype none
// ============================================================================
//  Module      : ib_chk
//  Description : Thumb-16 branch/IT checker. Registers branch and IT flags for
//                each accepted halfword and maintains the architectural
//                ITSTATE, exposed as cond.
//  Revision    : 1.0 - initial release
// ============================================================================
module ib_chk
  import ib_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_vld,
  input  logic [15:0] inst,
  output logic [7:0]  cond,
  output logic        b,
  output logic        it
);

  logic       w_b_d;
  logic       w_it_d;
  logic [7:0] w_itstate_nxt;
  logic [7:0] r_itstate;
  logic       r_b;
  logic       r_it;

  ib_chk_decode u_decode (
    .inst (inst),
    .b_d  (w_b_d),
    .it_d (w_it_d)
  );

  // Next ITSTATE for an accepted halfword: a new IT (nested or not) reloads,
  // otherwise an active block advances and an idle state holds.
  always_comb begin
    w_itstate_nxt = r_itstate;
    if (w_it_d) begin
      w_itstate_nxt = inst[7:0];
    end else if (r_itstate[3:0] != 4'h0) begin
      w_itstate_nxt = itstate_advance(r_itstate);
    end
  end

  // Output and ITSTATE registers; reset wins over any accepted halfword
  always_ff @(posedge clk) begin
    if (rst) begin
      r_itstate <= c_itstate_rst;
      r_b       <= 1'b0;
      r_it      <= 1'b0;
    end else if (inst_vld) begin
      r_itstate <= w_itstate_nxt;
      r_b       <= w_b_d;
      r_it      <= w_it_d;
    end else begin
      r_b       <= 1'b0;
      r_it      <= 1'b0;
    end
  end

  assign cond = r_itstate;
  assign b    = r_b;
  assign it   = r_it;

endmodule : ib_chk
`default_nettype wire

// File: tb/tb_ib_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ib_chk
//  Description : Self-checking bench for ib_chk: directed scenarios plus a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ib_chk;

  logic        clk;
  logic        rst;
  logic        inst_vld;
  logic [15:0] inst;
  logic [7:0]  cond;
  logic        b;
  logic        it;

  int checks;
  int errors;

  // Reference model state
  int m_cond;
  bit m_b;
  bit m_it;

  ib_chk dut (
    .clk      (clk),
    .rst      (rst),
    .inst_vld (inst_vld),
    .inst     (inst),
    .cond     (cond),
    .b        (b),
    .it       (it)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch classes expressed as numeric ranges/sets of the opcode fields
  function automatic bit ref_branch(input int x);
    int hi;
    int top9;
    hi   = x / 256;
    top9 = x / 128;
    if (hi >= 'hD0 && hi <= 'hDD) return 1'b1;
    if (hi >= 'hE0 && hi <= 'hE7) return 1'b1;
    if (top9 == 'h8E || top9 == 'h8F) return 1'b1;
    if (hi == 'hB1 || hi == 'hB3 || hi == 'hB9 || hi == 'hBB) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ref_it(input int x);
    return (x / 256 == 'hBF) && (x % 16 != 0);
  endfunction

  // One instruction through the IT block: the mask moves up one place
  function automatic int ref_next_cond(input int st, input int x);
    if (ref_it(x)) return x % 256;
    if (st % 16 == 0) return st;
    if (st % 8 == 0) return 0;
    return (st / 32) * 32 + ((st * 2) % 32);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cond"}, int'(cond), m_cond);
    check({tag, ".b"},    int'(b),    int'(m_b));
    check({tag, ".it"},   int'(it),   int'(m_it));
  endtask

  // Apply one cycle of stimulus, update the model, then compare
  task automatic step(input bit r, input bit v, input logic [15:0] x, input string tag);
    @(negedge clk);
    rst      = r;
    inst_vld = v;
    inst     = x;
    @(posedge clk);
    #1;
    if (r) begin
      m_cond = 0; m_b = 0; m_it = 0;
    end else if (v) begin
      m_cond = ref_next_cond(m_cond, int'(x));
      m_b    = ref_branch(int'(x));
      m_it   = ref_it(int'(x));
    end else begin
      m_b = 0; m_it = 0;
    end
    check_all(tag);
  endtask

  initial begin
    int bcount;
    logic [15:0] x;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    inst_vld = 1'b0;
    inst     = 16'h0000;
    m_cond = 0; m_b = 0; m_it = 0;

    // Reset state
    step(1'b1, 1'b1, 16'hBF12, "reset");
    check("reset_const.cond", int'(cond), 'h00);

    // 1. Opcode sweep with low byte 0x55
    bcount = 0;
    for (int hi = 0; hi < 256; hi++) begin
      x = {hi[7:0], 8'h55};
      step(1'b0, 1'b1, x, "sweep");
      if (b === 1'b1) bcount++;
    end
    check("sweep_branch_count", bcount, 27);

    // 2. IT expansion
    step(1'b1, 1'b0, 16'h0000, "rst2");
    step(1'b0, 1'b1, 16'hBF08, "it1");
    check("it1_const.cond", int'(cond), 'h08);
    check("it1_const.it", int'(it), 1);
    step(1'b0, 1'b1, 16'h0000, "it1_end");
    check("it1_end_const.cond", int'(cond), 'h00);
    step(1'b0, 1'b1, 16'hBF12, "it3");
    check("it3_const.cond0", int'(cond), 'h12);
    step(1'b0, 1'b1, 16'h0000, "it3a");
    check("it3_const.cond1", int'(cond), 'h04);
    step(1'b0, 1'b1, 16'hE000, "it3b_branch");
    check("it3_const.cond2", int'(cond), 'h08);
    check("it3_const.b", int'(b), 1);
    step(1'b0, 1'b1, 16'h0000, "it3c");
    check("it3_const.cond3", int'(cond), 'h00);

    // 3. Hint is not IT
    step(1'b0, 1'b1, 16'hBF10, "hint");
    check("hint_const.it", int'(it), 0);
    check("hint_const.cond", int'(cond), 'h00);

    // 4. Valid gating mid-block
    step(1'b0, 1'b1, 16'hBF12, "gate_it");
    step(1'b0, 1'b1, 16'h4770, "gate_bx");
    check("gate_const.cond", int'(cond), 'h04);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'hBF28, "gate_idle");
      check("gate_idle_const.cond", int'(cond), 'h04);
    end

    // 5. Nested IT then reset with a valid IT present
    step(1'b0, 1'b1, 16'hBF28, "nested");
    check("nested_const.cond", int'(cond), 'h28);
    step(1'b1, 1'b1, 16'hBF12, "rst_mid");
    check("rst_mid_const.cond", int'(cond), 'h00);
    check("rst_mid_const.it", int'(it), 0);

    // 6. Excluded encodings
    step(1'b0, 1'b1, 16'hDE00, "udf");
    step(1'b0, 1'b1, 16'hDF00, "svc");
    step(1'b0, 1'b1, 16'hF000, "prefix32");
    step(1'b0, 1'b1, 16'hB500, "push");
    check("push_const.b", int'(b), 0);

    // Randomized run, biased towards IT instructions and branches
    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      x = 16'($urandom);
      if (sel < 3) x[15:8] = 8'hBF;
      else if (sel < 5) x[15:12] = 4'($urandom_range(11, 14));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), x, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ib_chk
`default_nettype wire
